// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (req0) and load (req1) writeback using
// round-robin arbitration, with a pending-write busy scoreboard and a saturating stall counter.
module regfile_write_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_reg,
   output logic              regwrite,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic [NREG-1:0]   busy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              last_grant_q, last_grant_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   logic              gnt0, gnt1, hs, contended;
   logic [ADDR_W-1:0] win_reg;
   logic [DATA_W-1:0] win_data;
   logic [NREG-1:0]   set_mask, clr_mask;

   // Readys are forced low during reset so no handshake can be seen by a requester.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign hs         = gnt0 | gnt1;
   assign contended  = req0_valid & req1_valid;
   assign win_reg    = gnt1 ? req1_reg  : req0_reg;
   assign win_data   = gnt1 ? req1_data : req0_data;

   always_comb begin
      regwrite_d   = hs;
      write_reg_d  = hs ? win_reg  : write_reg_q;
      write_data_d = hs ? win_data : write_data_q;
      last_grant_d = hs ? gnt1     : last_grant_q;
      clr_mask     = hs ? (NREG'(1) << win_reg) : '0;
      set_mask     = rsv_valid ? (NREG'(1) << rsv_reg) : '0;
      // Set is applied after clear so a same-edge reservation keeps the bit busy.
      busy_d       = (busy_q & ~clr_mask) | set_mask;
      stall_d      = stall_q;
      if (contended && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         regwrite_q   <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
         stall_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         regwrite_q   <= regwrite_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
         stall_q      <= stall_d;
      end
   end

   assign regwrite   = regwrite_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;
   assign busy       = busy_q;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a transaction-level
// reference model (grant rule, write queue to a shadow register file, busy bit array).
module tb_regfile_write_arbiter;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int NR = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid, rsv_valid;
   logic [AW-1:0] req0_reg, req1_reg, rsv_reg;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready, regwrite;
   logic [AW-1:0] write_reg;
   logic [DW-1:0] write_data;
   logic [NR-1:0] busy;
   logic [CW-1:0] stall_cnt;

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
      .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
      .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // shadow register file fed by the DUT's write port
   logic [DW-1:0] rf [NR];
   always @(posedge clk) if (!rst && regwrite) rf[write_reg] <= write_data;

   // reference model
   int      m_last;
   bit      m_busy [NR];
   int      m_stall;
   bit      m_rw;
   int      m_wreg, m_wdata;
   int      m_rf [NR];
   int      last_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [NR-1:0] m_busy_vec();
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      m_last = 1; m_stall = 0; m_rw = 0; m_wreg = 0; m_wdata = 0;
      for (int i = 0; i < NR; i++) m_busy[i] = 0;
   endtask

   task automatic step(input bit v0, input int r0, input int d0,
                       input bit v1, input int r1, input int d1,
                       input bit rv, input int rr);
      int w;
      @(negedge clk);
      req0_valid = v0; req0_reg = AW'(r0); req0_data = DW'(d0);
      req1_valid = v1; req1_reg = AW'(r1); req1_data = DW'(d1);
      rsv_valid  = rv; rsv_reg  = AW'(rr);
      #1;
      if (v0 && v1)  w = (m_last == 0) ? 1 : 0;
      else if (v0)   w = 0;
      else if (v1)   w = 1;
      else           w = -1;
      chk("ready0", req0_ready, w == 0);
      chk("ready1", req1_ready, w == 1);
      if (m_rw) m_rf[m_wreg] = m_wdata;
      if (w >= 0) begin
         m_rw = 1;
         m_wreg  = (w == 1) ? r1 : r0;
         m_wdata = (w == 1) ? d1 : d0;
         m_last  = w;
         m_busy[m_wreg] = 0;
      end else begin
         m_rw = 0;
      end
      if (rv) m_busy[rr] = 1;
      if (v0 && v1 && m_stall < 255) m_stall++;
      @(posedge clk);
      #1;
      chk("regwrite",   regwrite,   m_rw);
      chk("write_reg",  write_reg,  m_wreg);
      chk("write_data", write_data, m_wdata);
      chk("busy",       busy,       m_busy_vec());
      chk("stall_cnt",  stall_cnt,  m_stall);
      last_w = w;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // async reset with both requesters still valid; checks outputs before any clock edge
   task automatic do_reset();
      @(negedge clk);
      req0_valid = 1; req1_valid = 1; rsv_valid = 0;
      rst = 1;
      #1;
      chk("rst_regwrite", regwrite, 0);
      chk("rst_wreg",     write_reg, 0);
      chk("rst_wdata",    write_data, 0);
      chk("rst_busy",     busy, 0);
      chk("rst_stall",    stall_cnt, 0);
      chk("rst_ready0",   req0_ready, 0);
      chk("rst_ready1",   req1_ready, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      req0_valid = 0; req1_valid = 0;
   endtask

   initial begin
      bit p0, p1;
      int r0, d0, r1, d1;
      rst = 1;
      req0_valid = 1; req1_valid = 1; rsv_valid = 0;
      req0_reg = 0; req1_reg = 0; rsv_reg = 0; req0_data = 0; req1_data = 0;
      for (int i = 0; i < NR; i++) m_rf[i] = 0;
      #1;
      for (int i = 0; i < NR; i++) rf[i] = '0;
      model_reset();
      do_reset();

      // round-robin from reset: grants 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 8'h11, 1, 2, 8'h22, 0, 0);
         chk("rr_grant", last_w, k % 2);
         chk("rr_wreg", write_reg, (k % 2 == 0) ? 1 : 2);
      end
      chk("rr_stall4", stall_cnt, 4);
      idle();

      // single requester 1
      step(0, 0, 0, 1, 5, 8'hA7, 0, 0);
      chk("single_wdata", write_data, 8'hA7);
      idle();
      chk("single_hold_reg", write_reg, 5);
      chk("single_hold_data", write_data, 8'hA7);

      // same-address contention: loser's data ends in the register
      do_reset();
      step(1, 3, 8'h10, 1, 3, 8'h20, 0, 0);
      chk("same_first", write_data, 8'h10);
      step(0, 0, 0, 1, 3, 8'h20, 0, 0);
      chk("same_second", write_data, 8'h20);
      idle();
      idle();
      chk("same_final", rf[3], 8'h20);

      // scoreboard set / same-edge set-wins / clear
      step(0, 0, 0, 0, 0, 0, 1, 4);
      chk("sb_set", busy, 8'h10);
      step(1, 4, 8'h55, 0, 0, 0, 1, 4);
      chk("sb_setwins", busy, 8'h10);
      step(1, 4, 8'h66, 0, 0, 0, 0, 0);
      chk("sb_clear", busy, 8'h00);
      chk("sb_clear_rw", regwrite, 1);
      idle();

      // randomized requesters that hold until accepted
      p0 = 0; p1 = 0; r0 = 0; d0 = 0; r1 = 0; d1 = 0;
      for (int k = 0; k < 400; k++) begin
         if (!p0 && ($urandom % 3 != 0)) begin p0 = 1; r0 = $urandom % NR; d0 = $urandom % 256; end
         if (!p1 && ($urandom % 3 != 0)) begin p1 = 1; r1 = $urandom % NR; d1 = $urandom % 256; end
         step(p0, r0, d0, p1, r1, d1, ($urandom % 4) == 0, $urandom % NR);
         if (last_w == 0) p0 = 0;
         if (last_w == 1) p1 = 0;
      end
      idle();
      idle();
      for (int i = 0; i < NR; i++) chk("rf_final", rf[i], m_rf[i]);

      // saturation, then asynchronous reset mid-stream
      for (int k = 0; k < 300; k++) step(1, k % NR, k % 256, 1, (k + 3) % NR, (k * 7) % 256, k % 5 == 0, k % NR);
      chk("sat_stall", stall_cnt, 255);
      do_reset();
      step(1, 6, 8'h3C, 1, 7, 8'hC3, 0, 0);
      chk("post_rst_grant", last_w, 0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
